// File: rtl/ddp_scaler.sv
// rtl/ddp_scaler.sv - frame-buffer address generator with integer pixel/line replication
// Fetches an HW x VH buffer upscaled by SCALE and returns blanked RGB three cycles later.
module ddp_scaler #(
   parameter int DW    = 15,
   parameter int HW    = 200,
   parameter int VH    = 150,
   parameter int SCALE = 4
) (
   input  logic          pclk,
   input  logic          rst,
   input  logic          hen,
   input  logic          ven,
   input  logic [11:0]   rdata,
   output logic [DW-1:0] raddr,
   output logic [11:0]   rgb,
   output logic          de
);

   localparam logic [DW-1:0] LAST_COL = DW'(HW - 1);
   localparam logic [DW-1:0] ROW_STEP = DW'(HW);
   localparam logic [DW-1:0] ROW_MAX  = DW'((VH - 1) * HW);
   localparam logic [2:0]    S_LAST   = 3'(SCALE - 1);

   logic          act;
   logic [DW-1:0] col_q, col_d;
   logic [DW-1:0] row_base_q, row_base_d;
   logic [2:0]    sx_q, sx_d;
   logic [2:0]    sy_q, sy_d;
   logic          act_d1_q, act_d1_d;
   logic          en_d1_q, en_d1_d;
   logic          en_d2_q, en_d2_d;
   logic [DW-1:0] raddr_q, raddr_d;
   logic [11:0]   rgb_q, rgb_d;
   logic          de_q, de_d;

   assign act = hen & ven;

   always_comb begin
      col_d      = col_q;
      row_base_d = row_base_q;
      sx_d       = sx_q;
      sy_d       = sy_q;
      raddr_d    = raddr_q;
      act_d1_d   = act;
      en_d1_d    = act;
      en_d2_d    = en_d1_q;
      rgb_d      = en_d2_q ? rdata : 12'h000;
      de_d       = en_d2_q;

      // Frame reset wins over line end when hen and ven fall together.
      if (!ven) begin
         col_d      = '0;
         row_base_d = '0;
         sx_d       = '0;
         sy_d       = '0;
      end else if (act) begin
         raddr_d = row_base_q + col_q;
         if (sx_q == S_LAST) begin
            sx_d = '0;
            if (col_q != LAST_COL) col_d = col_q + 1'b1;
         end else begin
            sx_d = sx_q + 1'b1;
         end
      end else if (act_d1_q) begin
         col_d = '0;
         sx_d  = '0;
         if (sy_q == S_LAST) begin
            sy_d = '0;
            if (row_base_q != ROW_MAX) row_base_d = row_base_q + ROW_STEP;
         end else begin
            sy_d = sy_q + 1'b1;
         end
      end
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         col_q      <= '0;
         row_base_q <= '0;
         sx_q       <= '0;
         sy_q       <= '0;
         act_d1_q   <= 1'b0;
         en_d1_q    <= 1'b0;
         en_d2_q    <= 1'b0;
         raddr_q    <= '0;
         rgb_q      <= '0;
         de_q       <= 1'b0;
      end else begin
         col_q      <= col_d;
         row_base_q <= row_base_d;
         sx_q       <= sx_d;
         sy_q       <= sy_d;
         act_d1_q   <= act_d1_d;
         en_d1_q    <= en_d1_d;
         en_d2_q    <= en_d2_d;
         raddr_q    <= raddr_d;
         rgb_q      <= rgb_d;
         de_q       <= de_d;
      end
   end

   assign raddr = raddr_q;
   assign rgb   = rgb_q;
   assign de    = de_q;

endmodule

// File: tb/tb_ddp_scaler.sv
// tb/tb_ddp_scaler.sv - self-checking bench for ddp_scaler at default and small geometries
// Two instances share stimulus; a pixel/line-count model predicts addresses and outputs.
module tb_ddp_scaler;

   logic        pclk = 1'b0;
   logic        rst, hen, ven;
   logic        ram_ff;
   logic [11:0] rdata_a, rdata_b;
   logic [14:0] raddr_a;
   logic [7:0]  raddr_b;
   logic [11:0] rgb_a, rgb_b;
   logic        de_a, de_b;

   always #5 pclk = ~pclk;

   ddp_scaler #(.DW(15), .HW(200), .VH(150), .SCALE(4)) dut_a (
      .pclk(pclk), .rst(rst), .hen(hen), .ven(ven), .rdata(rdata_a),
      .raddr(raddr_a), .rgb(rgb_a), .de(de_a));

   ddp_scaler #(.DW(8), .HW(10), .VH(6), .SCALE(2)) dut_b (
      .pclk(pclk), .rst(rst), .hen(hen), .ven(ven), .rdata(rdata_b),
      .raddr(raddr_b), .rgb(rgb_b), .de(de_b));

   // Synchronous-read frame buffer whose contents equal the address (or all ones).
   always @(posedge pclk) begin
      rdata_a <= ram_ff ? 12'hFFF : raddr_a[11:0];
      rdata_b <= ram_ff ? 12'hFFF : {4'h0, raddr_b};
   end

   int checks = 0;
   int failures = 0;
   int p, l_cnt, ma, mb;
   logic prev_act;
   logic hact [0:2];
   int   hadr_a [0:2];
   int   hadr_b [0:2];
   int   dcount, len, blk;

   typedef struct {
      logic h, v, r;
      int   raddr;
      logic de;
   } vec_t;
   vec_t tbl [0:10];

   function automatic int fetch(input int pix, input int line, input int hw, input int vh, input int sc);
      int c, r;
      c = pix / sc;
      if (c > hw - 1) c = hw - 1;
      r = line / sc;
      if (r > vh - 1) r = vh - 1;
      return r * hw + c;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic h, input logic v, input logic r);
      logic a;
      a = h & v;
      hen = h; ven = v; rst = r;
      @(posedge pclk);
      if (r) begin
         p = 0; l_cnt = 0; ma = 0; mb = 0; prev_act = 1'b0;
         for (int i = 0; i < 3; i++) begin
            hact[i] = 1'b0; hadr_a[i] = 0; hadr_b[i] = 0;
         end
      end else begin
         if (a) begin
            ma = fetch(p, l_cnt, 200, 150, 4);
            mb = fetch(p, l_cnt, 10, 6, 2);
            p++;
         end else if (!v) begin
            p = 0; l_cnt = 0;
         end else if (prev_act) begin
            p = 0; l_cnt++;
         end
         prev_act = a;
         for (int i = 2; i > 0; i--) begin
            hact[i] = hact[i-1]; hadr_a[i] = hadr_a[i-1]; hadr_b[i] = hadr_b[i-1];
         end
         hact[0] = a; hadr_a[0] = ma; hadr_b[0] = mb;
      end
      #1;
      chk("raddr_a", int'(raddr_a), ma);
      chk("raddr_b", int'(raddr_b), mb);
      chk("de_a", int'(de_a), int'(hact[2]));
      chk("de_b", int'(de_b), int'(hact[2]));
      chk("rgb_a", int'(rgb_a), hact[2] ? (ram_ff ? 4095 : (hadr_a[2] & 4095)) : 0);
      chk("rgb_b", int'(rgb_b), hact[2] ? (ram_ff ? 4095 : (hadr_b[2] & 4095)) : 0);
   endtask

   task automatic run_line(input int n, input int blank);
      repeat (n) step(1'b1, 1'b1, 1'b0);
      repeat (blank) step(1'b0, 1'b1, 1'b0);
   endtask

   initial begin
      rst = 1'b1; hen = 1'b0; ven = 1'b0; ram_ff = 1'b0;
      tbl[0]  = '{1'b1, 1'b1, 1'b1, 0, 1'b0};
      tbl[1]  = '{1'b1, 1'b1, 1'b0, 0, 1'b0};
      tbl[2]  = '{1'b1, 1'b1, 1'b0, 0, 1'b0};
      tbl[3]  = '{1'b1, 1'b1, 1'b0, 0, 1'b1};
      tbl[4]  = '{1'b1, 1'b1, 1'b0, 0, 1'b1};
      tbl[5]  = '{1'b1, 1'b1, 1'b0, 1, 1'b1};
      tbl[6]  = '{1'b1, 1'b1, 1'b0, 1, 1'b1};
      tbl[7]  = '{1'b0, 1'b1, 1'b0, 1, 1'b1};
      tbl[8]  = '{1'b0, 1'b1, 1'b0, 1, 1'b1};
      tbl[9]  = '{1'b0, 1'b1, 1'b0, 1, 1'b0};
      tbl[10] = '{1'b1, 1'b1, 1'b0, 0, 1'b0};

      repeat (3) step(1'b0, 1'b0, 1'b1);
      chk("reset_raddr", int'(raddr_a), 0);
      chk("reset_rgb", int'(rgb_a), 0);
      chk("reset_de", int'(de_a), 0);

      for (int i = 0; i < 11; i++) begin
         step(tbl[i].h, tbl[i].v, tbl[i].r);
         chk("tbl_raddr", int'(raddr_a), tbl[i].raddr);
         chk("tbl_de", int'(de_a), int'(tbl[i].de));
      end
      repeat (10) step(1'b0, 1'b0, 1'b0);

      // Reset mid-line at pixel 37.
      repeat (37) step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1);
      chk("midrst_raddr", int'(raddr_a), 0);
      chk("midrst_rgb", int'(rgb_a), 0);
      chk("midrst_de", int'(de_a), 0);
      step(1'b1, 1'b1, 1'b0);
      chk("midrst_next_raddr", int'(raddr_a), 0);
      run_line(20, 5);
      repeat (10) step(1'b0, 1'b0, 1'b0);

      // First line plus replication over 8 lines.
      dcount = 0;
      for (int ln = 0; ln < 8; ln++) begin
         for (int i = 0; i < 960; i++) begin
            step(i < 800, 1'b1, 1'b0);
            if (ln == 0 && de_a) dcount++;
            if (i == 799 && ln == 0) chk("line0_last", int'(raddr_a), 199);
            if (i == 0 && ln == 4) chk("line4_first", int'(raddr_a), 200);
            if (i == 799 && ln == 7) chk("line7_last", int'(raddr_a), 399);
         end
      end
      chk("line0_de_count", dcount, 800);
      repeat (10) step(1'b0, 1'b0, 1'b0);

      // Overlong line saturates at column HW-1.
      for (int i = 0; i < 1000; i++) begin
         step(1'b1, 1'b1, 1'b0);
         if (i == 795) chk("ovf_795", int'(raddr_a), 198);
         if (i == 796) chk("ovf_796", int'(raddr_a), 199);
         if (i == 999) chk("ovf_999", int'(raddr_a), 199);
      end
      repeat (5) step(1'b0, 1'b1, 1'b0);
      repeat (10) step(1'b0, 1'b0, 1'b0);

      // Small instance: full frame, frame wrap, then excess lines.
      repeat (12) run_line(20, 3);
      chk("b_frame_last", int'(raddr_b), 59);
      repeat (10) step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      chk("b_wrap_first", int'(raddr_b), 0);
      chk("a_wrap_first", int'(raddr_a), 0);
      run_line(24, 2);
      for (int ln = 1; ln < 14; ln++) begin
         step(1'b1, 1'b1, 1'b0);
         if (ln == 12) chk("b_excess_first", int'(raddr_b), 50);
         run_line(24, 2);
      end
      chk("b_excess_last", int'(raddr_b), 59);
      repeat (10) step(1'b0, 1'b0, 1'b0);

      // Blanking with an all-ones RAM.
      ram_ff = 1'b1;
      repeat (5) step(1'b0, 1'b0, 1'b0);
      run_line(20, 0);
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b1, 1'b0);
         if (i == 1) chk("blank_last_rgb", int'(rgb_a), 4095);
         if (i >= 2) begin
            chk("blank_rgb", int'(rgb_a), 0);
            chk("blank_de", int'(de_a), 0);
         end
      end
      repeat (5) step(1'b0, 1'b0, 1'b0);
      ram_ff = 1'b0;
      repeat (5) step(1'b0, 1'b0, 1'b0);

      // Randomised lines, blanks, frame drops and simultaneous hen/ven fall.
      for (int n = 0; n < 40; n++) begin
         len = $urandom_range(1, 400);
         blk = $urandom_range(1, 12);
         repeat (len) step(1'b1, 1'b1, 1'b0);
         if ($urandom_range(0, 7) == 0) begin
            repeat (blk) step(1'b0, 1'b0, 1'b0);
         end else begin
            repeat (blk) step(1'b0, 1'b1, 1'b0);
         end
      end
      repeat (5) step(1'b0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
